evict_wbuf_n: RTL and testbench

- Parametrised, multi-entry successor to the single-line eviction write buffer; sits between the L2 cache (upstream, mem_*) and physical memory (downstream, pmem_*).
- Absorbs DEPTH dirty-line evictions in a FIFO, coalesces repeat writes to the same line, and forwards buffered data on read hits.
- Drains to memory only when upstream is idle or the buffer is full, so L2 read misses are never queued behind writebacks.

---
 rtl/wbuf_pkg.sv | 8 +
 rtl/wbuf_match.sv | 30 +++
 rtl/evict_wbuf_n.sv | 133 +++++++++++++
 tb/tb_evict_wbuf_n.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/wbuf_pkg.sv
// wbuf_pkg: shared FSM state type and line-address helper for the eviction write buffer
package wbuf_pkg;
  typedef enum logic [2:0] {IDLE, RD_HIT, RD_MEM, WR_ACK, DRAIN} wbuf_state_t;
  // Drops the byte-offset bits so two addresses in one line compare equal.
  function automatic logic [63:0] line_addr(input logic [63:0] addr, input int unsigned offset_w);
    return addr >> offset_w;
  endfunction
endpackage

// File: rtl/wbuf_match.sv
// wbuf_match: parallel line-tag compare; youngest-first one-hot for reads, drain-excluded hits for writes
// Ports: i_tag request line tag; i_tags/i_valid entry tags and valid bits; i_head oldest entry;
//        i_drain head is being drained; o_rd_vec one-hot youngest read hit; o_wr_vec write hits.
module wbuf_match #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 27
) (
  input  logic [TAG_W-1:0]         i_tag,
  input  logic [DEPTH*TAG_W-1:0]   i_tags,
  input  logic [DEPTH-1:0]         i_valid,
  input  logic [$clog2(DEPTH)-1:0] i_head,
  input  logic                     i_drain,
  output logic [DEPTH-1:0]         o_rd_vec,
  output logic [DEPTH-1:0]         o_wr_vec
);
  localparam int PW = $clog2(DEPTH);
  logic [DEPTH-1:0] w_eq;
  logic [PW-1:0]    w_rd_idx;
  for (genvar i = 0; i < DEPTH; i++) begin : g_eq
    assign w_eq[i] = i_valid[i] && (i_tags[i*TAG_W +: TAG_W] == i_tag);
  end
  // Walk oldest to youngest so the last hit seen is the youngest one.
  always_comb begin
    w_rd_idx = '0;
    for (int k = 0; k < DEPTH; k++)
      if (w_eq[(int'(i_head) + k) % DEPTH]) w_rd_idx = PW'((int'(i_head) + k) % DEPTH);
    o_rd_vec = |w_eq ? DEPTH'(1) << w_rd_idx : '0;
    o_wr_vec = w_eq & ~(i_drain ? DEPTH'(1) << i_head : '0);
  end
endmodule

// File: rtl/evict_wbuf_n.sv
// evict_wbuf_n: DEPTH-entry dirty-line eviction FIFO between L2 (mem_*) and memory (pmem_*)
// Ports: mem_* upstream line requests (read/write held until mem_resp pulse);
//        pmem_* downstream memory port (read/write held until pmem_resp);
//        full/empty/occupancy buffer status from registered count.
// Optional: define WBUF_PERF_CNT_EN to add perf_rd_hits, perf_coalesces, perf_full_stalls
//           32-bit saturating counters.
module evict_wbuf_n
  import wbuf_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int LINE_W   = 256,
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADDR_W-1:0]          mem_address,
  input  logic                       mem_read,
  input  logic                       mem_write,
  input  logic [LINE_W-1:0]          mem_wdata,
  output logic [LINE_W-1:0]          mem_rdata,
  output logic                       mem_resp,
  output logic [ADDR_W-1:0]          pmem_address,
  output logic                       pmem_read,
  output logic                       pmem_write,
  output logic [LINE_W-1:0]          pmem_wdata,
  input  logic [LINE_W-1:0]          pmem_rdata,
  input  logic                       pmem_resp,
`ifdef WBUF_PERF_CNT_EN
  output logic [31:0]                perf_rd_hits,
  output logic [31:0]                perf_coalesces,
  output logic [31:0]                perf_full_stalls,
`endif
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     occupancy
);
  localparam int TAG_W = ADDR_W - OFFSET_W;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH) + 1;
  wbuf_state_t              r_state, w_next;
  logic [DEPTH-1:0]         r_valid, r_hit_vec;
  logic [DEPTH*TAG_W-1:0]   r_tags;
  logic [LINE_W-1:0]        r_data [DEPTH];
  logic [PW-1:0]            r_head, r_tail;
  logic [CW-1:0]            r_count;
  logic [TAG_W-1:0]         w_tag;
  logic [DEPTH-1:0]         w_rd_vec, w_wr_vec, w_wsel;
  logic [LINE_W-1:0]        w_hit_data;
  logic                     w_full, w_empty, w_rd_hit, w_wr_hit, w_acc_wr, w_alloc, w_pop;
  assign w_tag    = TAG_W'(line_addr(64'(mem_address), OFFSET_W));
  assign w_full   = r_count == CW'(DEPTH);
  assign w_empty  = r_count == '0;
  assign w_rd_hit = |w_rd_vec;
  assign w_wr_hit = |w_wr_vec;
  assign w_acc_wr = r_state == IDLE && !mem_read && mem_write && (w_wr_hit || !w_full);
  assign w_alloc  = w_acc_wr && !w_wr_hit;
  assign w_pop    = r_state == DRAIN && pmem_resp;
  // A coalescing write targets its match; a fresh line lands at the tail.
  assign w_wsel   = w_wr_hit ? w_wr_vec : DEPTH'(1) << r_tail;
  assign full      = w_full;
  assign empty     = w_empty;
  assign occupancy = r_count;
  wbuf_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_match (
    .i_tag   (w_tag),
    .i_tags  (r_tags),
    .i_valid (r_valid),
    .i_head  (r_head),
    .i_drain (r_state == DRAIN),
    .o_rd_vec(w_rd_vec),
    .o_wr_vec(w_wr_vec)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  // Reads beat writes; a full buffer or an idle upstream triggers a single-line drain.
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:          w_next = mem_read ? (w_rd_hit ? RD_HIT : RD_MEM) :
                              mem_write ? (w_acc_wr ? WR_ACK : DRAIN) :
                              w_empty ? IDLE : DRAIN;
      RD_MEM, DRAIN: w_next = pmem_resp ? IDLE : r_state;
      default:       w_next = IDLE;
    endcase
  end
  always_comb begin
    w_hit_data = '0;
    for (int k = 0; k < DEPTH; k++) if (r_hit_vec[k]) w_hit_data = r_data[k];
  end
  always_comb begin
    mem_resp     = r_state == RD_HIT || r_state == WR_ACK || (r_state == RD_MEM && pmem_resp);
    mem_rdata    = r_state == RD_HIT ? w_hit_data : r_state == RD_MEM ? pmem_rdata : '0;
    pmem_read    = r_state == RD_MEM;
    pmem_write   = r_state == DRAIN;
    pmem_address = r_state == RD_MEM ? {w_tag, {OFFSET_W{1'b0}}} :
                   r_state == DRAIN  ? {r_tags[r_head*TAG_W +: TAG_W], {OFFSET_W{1'b0}}} : '0;
    pmem_wdata   = r_state == DRAIN ? r_data[r_head] : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_valid   <= '0;
      r_hit_vec <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
    end else begin
      if (r_state == IDLE && mem_read) r_hit_vec <= w_rd_vec;
      r_valid <= (r_valid | (w_alloc ? w_wsel : '0)) & ~(w_pop ? DEPTH'(1) << r_head : '0);
      if (w_alloc) r_tail <= r_tail + 1'b1;
      if (w_pop) r_head <= r_head + 1'b1;
      r_count <= r_count + CW'(w_alloc) - CW'(w_pop);
    end
  // Line payloads are qualified by r_valid, so they need no reset.
  always_ff @(posedge clk)
    for (int k = 0; k < DEPTH; k++)
      if (w_acc_wr && w_wsel[k]) begin
        r_data[k]                   <= mem_wdata;
        r_tags[k*TAG_W +: TAG_W]    <= w_tag;
      end
`ifdef WBUF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_rd_hits     <= '0;
      perf_coalesces   <= '0;
      perf_full_stalls <= '0;
    end else begin
      if (r_state == IDLE && mem_read && w_rd_hit && ~&perf_rd_hits) perf_rd_hits <= perf_rd_hits + 1;
      if (w_acc_wr && w_wr_hit && ~&perf_coalesces) perf_coalesces <= perf_coalesces + 1;
      if (r_state == IDLE && mem_write && w_full && ~&perf_full_stalls) perf_full_stalls <= perf_full_stalls + 1;
    end
`endif
endmodule

// File: tb/tb_evict_wbuf_n.sv
// tb_evict_wbuf_n: scoreboard bench with a line-level FIFO/memory reference model
module tb_evict_wbuf_n;
  localparam int DEPTH = 4, LINE_W = 256, ADDR_W = 32, OFFSET_W = 5;
  logic clk, rst_n;
  logic [ADDR_W-1:0] mem_address, pmem_address;
  logic mem_read, mem_write, mem_resp, pmem_read, pmem_write, pmem_resp, full, empty;
  logic [LINE_W-1:0] mem_wdata, mem_rdata, pmem_wdata, pmem_rdata;
  logic [2:0] occupancy;
  evict_wbuf_n #(.DEPTH(DEPTH), .LINE_W(LINE_W), .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W)) dut (
    .clk(clk), .rst_n(rst_n), .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp), .pmem_address(pmem_address),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp), .full(full), .empty(empty), .occupancy(occupancy));
  initial begin clk = 0; forever #5 clk = ~clk; end
  typedef struct {
    bit rd; logic [31:0] line; logic [255:0] data;
    int t0; int exp_lat; int pw0; int pr0; int exp_dpw; int exp_dpr;
  } exp_t;
  exp_t sb[$];
  logic [31:0]  mq_line[$];
  logic [255:0] mq_data[$];
  logic [255:0] mem[logic [31:0]];
  int n_vec = 0, n_err = 0, cyc = 0, rsp_delay = 1, wcnt = 0, pw_cnt = 0, pr_cnt = 0;
  always @(posedge clk) cyc++;
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  function automatic int find(input logic [31:0] ln);
    for (int i = 0; i < mq_line.size(); i++) if (mq_line[i] == ln) return i;
    return -1;
  endfunction
  function automatic logic [255:0] mem_val(input logic [31:0] ln);
    logic [31:0] p = ln ^ 32'h5A5A_0000;
    return mem.exists(ln) ? mem[ln] : {8{p}};
  endfunction
  function automatic logic [255:0] cur_val(input logic [31:0] ln);
    int i = find(ln);
    return i >= 0 ? mq_data[i] : mem_val(ln);
  endfunction
  function automatic logic [255:0] rnd_line();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction
  // Memory model: answers after rsp_delay cycles; every drain must be the oldest model line.
  initial begin
    pmem_resp = 0; pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      pmem_resp = 0;
      if (!rst_n || !(pmem_read || pmem_write)) begin wcnt = 0; continue; end
      if (pmem_read) pmem_rdata = mem_val(pmem_address >> 5);
      if (wcnt < rsp_delay) begin wcnt++; continue; end
      wcnt = 0;
      pmem_resp = 1;
      chk("pmem_addr_align", 256'(pmem_address[4:0]), 256'(0));
      if (pmem_read) pr_cnt++;
      else begin
        pw_cnt++;
        if (mq_line.size() == 0) chk("drain_unexpected", 256'(1), 256'(0));
        else begin
          chk("drain_addr", 256'(pmem_address), 256'(mq_line[0] << 5));
          chk("drain_data", pmem_wdata, mq_data[0]);
          mem[mq_line[0]] = mq_data[0];
          void'(mq_line.pop_front());
          void'(mq_data.pop_front());
        end
      end
    end
  end
  // Monitor: pops the scoreboard on every upstream response.
  initial forever begin
    exp_t e;
    int i;
    @(negedge clk);
    if (!(rst_n && mem_resp)) continue;
    if (sb.size() == 0) begin chk("resp_unexpected", 256'(1), 256'(0)); continue; end
    e = sb.pop_front();
    if (e.rd) chk("rd_data", mem_rdata, e.data);
    else begin
      i = find(e.line);
      if (i >= 0) mq_data[i] = e.data;
      else begin mq_line.push_back(e.line); mq_data.push_back(e.data); end
      chk("occupancy", 256'(occupancy), 256'(mq_line.size()));
      chk("full", 256'(full), 256'(mq_line.size() == DEPTH));
      chk("empty", 256'(empty), 256'(mq_line.size() == 0));
    end
    if (e.exp_lat > 0) chk("latency", 256'(cyc - e.t0 + 1), 256'(e.exp_lat));
    if (e.exp_dpw >= 0) chk("pmem_wr_count", 256'(pw_cnt - e.pw0), 256'(e.exp_dpw));
    if (e.exp_dpr >= 0) chk("pmem_rd_count", 256'(pr_cnt - e.pr0), 256'(e.exp_dpr));
  end
  // Issue one request; b2b means it directly follows a response so the buffer sits in IDLE.
  task automatic req(input bit rd, input logic [31:0] addr, input logic [255:0] data, input bit b2b);
    exp_t e;
    logic [31:0] ln = addr >> 5;
    int i = find(ln);
    int n = 0;
    e.rd = rd; e.line = ln; e.data = rd ? cur_val(ln) : data;
    e.t0 = cyc; e.pw0 = pw_cnt; e.pr0 = pr_cnt;
    e.exp_lat = (b2b && (rd ? i >= 0 : (i >= 0 || mq_line.size() < DEPTH))) ? 2 : 0;
    e.exp_dpw = b2b ? ((!rd && i < 0 && mq_line.size() == DEPTH) ? 1 : 0) : -1;
    e.exp_dpr = b2b ? ((rd && i < 0) ? 1 : 0) : -1;
    sb.push_back(e);
    mem_address = addr; mem_read = rd; mem_write = !rd; mem_wdata = data;
    do begin @(negedge clk); n++; end while (!mem_resp && n < 2000);
    if (!mem_resp) begin chk("resp_timeout", 256'(0), 256'(1)); void'(sb.pop_back()); end
    @(posedge clk); #1;
    mem_read = 0; mem_write = 0;
  endtask
  task automatic wait_empty();
    int n = 0;
    while ((!empty || mq_line.size() != 0) && n < 1000) begin @(negedge clk); n++; end
    chk("drained_empty", 256'(empty), 256'(1));
    chk("drained_model", 256'(mq_line.size()), 256'(0));
    @(posedge clk); #1;
  endtask
  initial begin
    int p0, g;
    rst_n = 0; mem_address = 0; mem_read = 0; mem_write = 0; mem_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_empty", 256'(empty), 256'(1));
    chk("rst_full", 256'(full), 256'(0));
    chk("rst_occ", 256'(occupancy), 256'(0));
    chk("rst_outs", 256'({mem_resp, pmem_read, pmem_write}), 256'(0));
    rst_n = 1;
    @(posedge clk); #1;
    req(0, 32'h1000, {8{32'hAAAA_0001}}, 1);
    req(0, 32'h2000, {8{32'hBBBB_0002}}, 1);
    wait_empty();
    p0 = pw_cnt;
    req(0, 32'h1000, {8{32'h0000_000A}}, 1);
    req(0, 32'h1004, {8{32'h0000_000B}}, 1);
    wait_empty();
    chk("coalesce_one_drain", 256'(pw_cnt - p0), 256'(1));
    req(0, 32'h3000, {8{32'hCCCC_0003}}, 1);
    req(1, 32'h3010, '0, 1);
    wait_empty();
    for (int i = 0; i < 4; i++) req(0, 32'(i * 32), rnd_line(), 1);
    req(0, 32'h80, rnd_line(), 1);
    wait_empty();
    req(0, 32'h5000, rnd_line(), 1);
    req(0, 32'h5020, rnd_line(), 1);
    req(1, 32'h4000, '0, 1);
    wait_empty();
    for (int t = 0; t < 300; t++) begin
      rsp_delay = $urandom_range(0, 3);
      g = ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, 5);
      repeat (g) @(posedge clk);
      if (g != 0) #1;
      req($urandom_range(0, 1) == 1, 32'h8000 + 32'($urandom_range(0, 7) << 5) + 32'($urandom_range(0, 31)),
          rnd_line(), g == 0);
    end
    rsp_delay = 1;
    wait_empty();
    rsp_delay = 1000;
    req(0, 32'h6000, rnd_line(), 1);
    g = 0;
    while (!pmem_write && g < 50) begin @(negedge clk); g++; end
    chk("drain_started", 256'(pmem_write), 256'(1));
    #2 rst_n = 0;
    #1;
    chk("arst_pmem_write", 256'(pmem_write), 256'(0));
    chk("arst_outs", 256'({mem_resp, pmem_read, full}), 256'(0));
    chk("arst_addr_data", pmem_wdata | 256'(pmem_address) | mem_rdata, '0);
    chk("arst_empty", 256'(empty), 256'(1));
    chk("arst_occ", 256'(occupancy), 256'(0));
    mq_line.delete(); mq_data.delete();
    rsp_delay = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle", 256'({pmem_write, pmem_read, empty}), 256'(1));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
